// File: rtl/vend_pkg.sv
// Types and codes shared by the payout controller and the vending controller.
package vend_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VEND,
        ST_PULSE,
        ST_WAIT_COIN,
        ST_DONE,
        ST_FAULT
    } vend_state_e;

    localparam logic [1:0] CHG_NONE = 2'b00;
    localparam logic [1:0] CHG_5    = 2'b01;
    localparam logic [1:0] CHG_10   = 2'b10;
    localparam logic [1:0] CHG_BAD  = 2'b11;

    typedef enum logic [1:0] {
        FLT_NONE    = 2'b00,
        FLT_TIMEOUT = 2'b01,
        FLT_BADREQ  = 2'b10
    } vend_fault_e;

    typedef struct packed {
        logic       bottle;
        logic [1:0] change;
    } vend_req_t;

    // Number of 5 rs coins owed for a change code.
    function automatic logic [1:0] coins_for(input logic [1:0] chg);
        case (chg)
            CHG_5:   return 2'd1;
            CHG_10:  return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/vend_cycle_timer.sv
// Loadable down-counter that parks at zero; zero_c flags an expired interval.
module vend_cycle_timer #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero_c
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero_c = (cnt == '0);

endmodule

// File: rtl/vend_payout_ctrl.sv
// Payout actuator controller: runs the bottle motor, then pulses the coin hopper
// once per coin owed, confirming each drop on the coin sensor with retry/timeout.
module vend_payout_ctrl
    import vend_pkg::*;
#(
    parameter int unsigned MOTOR_CYCLES   = 8,
    parameter int unsigned PULSE_CYCLES   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned MAX_RETRY      = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    input  logic       req_bottle,
    input  logic [1:0] req_change,
    output logic       req_ready,
    output logic       motor_on,
    output logic       hopper_pulse,
    input  logic       coin_sense,
    output logic       busy,
    output logic       done,
    output logic [1:0] coins_paid,
    output logic       fault,
    output logic [1:0] fault_code,
    input  logic       fault_clr
);

    localparam int unsigned TW = $clog2(max3(MOTOR_CYCLES, PULSE_CYCLES, TIMEOUT_CYCLES) + 1);
    localparam int unsigned RW = $clog2(MAX_RETRY + 2);

    vend_state_e state, state_nxt;
    vend_fault_e code_q, code_nxt;
    vend_req_t   req;
    logic [1:0]  owed, owed_nxt;
    logic [1:0]  paid_nxt;
    logic [RW-1:0] retry, retry_nxt;
    logic          tmr_load, tmr_zero_c, take_drop;
    logic [TW-1:0] tmr_val;
    logic          coin_q, coin_edge_c;

    assign req         = '{bottle: req_bottle, change: req_change};
    assign coin_edge_c = coin_sense && !coin_q;

    vend_cycle_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero_c   (tmr_zero_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        code_nxt  = code_q;
        owed_nxt  = owed;
        paid_nxt  = coins_paid;
        retry_nxt = retry;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        take_drop = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    paid_nxt = '0;
                    owed_nxt = coins_for(req.change);
                    if (req.change == CHG_BAD) begin
                        state_nxt = ST_FAULT;
                        code_nxt  = FLT_BADREQ;
                    end else if (req.bottle) begin
                        state_nxt = ST_VEND;
                        tmr_load  = 1'b1;
                        tmr_val   = TW'(MOTOR_CYCLES - 1);
                    end else if (owed_nxt != 2'd0) begin
                        state_nxt = ST_PULSE;
                        tmr_load  = 1'b1;
                        tmr_val   = TW'(PULSE_CYCLES - 1);
                        retry_nxt = '0;
                    end else begin
                        state_nxt = ST_DONE;
                    end
                end
            end
            ST_VEND: begin
                if (tmr_zero_c) begin
                    if (owed != 2'd0) begin
                        state_nxt = ST_PULSE;
                        tmr_load  = 1'b1;
                        tmr_val   = TW'(PULSE_CYCLES - 1);
                        retry_nxt = '0;
                    end else begin
                        state_nxt = ST_DONE;
                    end
                end
            end
            ST_PULSE: begin
                if (coin_edge_c) begin
                    take_drop = 1'b1;
                end else if (tmr_zero_c) begin
                    state_nxt = ST_WAIT_COIN;
                    tmr_load  = 1'b1;
                    tmr_val   = TW'(TIMEOUT_CYCLES - 1);
                end
            end
            ST_WAIT_COIN: begin
                if (coin_edge_c) begin
                    take_drop = 1'b1;
                end else if (tmr_zero_c) begin
                    if (retry < RW'(MAX_RETRY)) begin
                        retry_nxt = retry + RW'(1);
                        state_nxt = ST_PULSE;
                        tmr_load  = 1'b1;
                        tmr_val   = TW'(PULSE_CYCLES - 1);
                    end else begin
                        state_nxt = ST_FAULT;
                        code_nxt  = FLT_TIMEOUT;
                    end
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            ST_FAULT: begin
                if (fault_clr) begin
                    state_nxt = ST_IDLE;
                    code_nxt  = FLT_NONE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // A confirmed drop settles one coin; the next coin starts with fresh retries.
        if (take_drop) begin
            paid_nxt = coins_paid + 2'd1;
            owed_nxt = owed - 2'd1;
            if (owed == 2'd1) begin
                state_nxt = ST_DONE;
            end else begin
                state_nxt = ST_PULSE;
                tmr_load  = 1'b1;
                tmr_val   = TW'(PULSE_CYCLES - 1);
                retry_nxt = '0;
            end
        end
    end

    // Datapath registers and outputs decoded from the next state, so they track state exactly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            code_q       <= FLT_NONE;
            owed         <= '0;
            coins_paid   <= '0;
            retry        <= '0;
            coin_q       <= 1'b0;
            req_ready    <= 1'b1;
            motor_on     <= 1'b0;
            hopper_pulse <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            fault        <= 1'b0;
        end else begin
            code_q       <= code_nxt;
            owed         <= owed_nxt;
            coins_paid   <= paid_nxt;
            retry        <= retry_nxt;
            coin_q       <= coin_sense;
            req_ready    <= (state_nxt == ST_IDLE);
            motor_on     <= (state_nxt == ST_VEND);
            hopper_pulse <= (state_nxt == ST_PULSE);
            busy         <= (state_nxt != ST_IDLE) && (state_nxt != ST_FAULT);
            done         <= (state_nxt == ST_DONE);
            fault        <= (state_nxt == ST_FAULT);
        end
    end

    assign fault_code = code_q;

endmodule

// File: tb/tb_vend_payout_ctrl.sv
// Scoreboard bench for vend_payout_ctrl: randomized payouts against a transaction-level model.
module tb_vend_payout_ctrl;

    localparam int M = 8;
    localparam int P = 4;
    localparam int T = 16;
    localparam int R = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid, req_bottle;
    logic [1:0] req_change;
    logic       req_ready, motor_on, hopper_pulse, coin_sense;
    logic       busy, done, fault, fault_clr;
    logic [1:0] coins_paid, fault_code;

    vend_payout_ctrl #(
        .MOTOR_CYCLES(M), .PULSE_CYCLES(P), .TIMEOUT_CYCLES(T), .MAX_RETRY(R)
    ) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_bottle(req_bottle),
        .req_change(req_change), .req_ready(req_ready), .motor_on(motor_on),
        .hopper_pulse(hopper_pulse), .coin_sense(coin_sense), .busy(busy),
        .done(done), .coins_paid(coins_paid), .fault(fault), .fault_code(fault_code),
        .fault_clr(fault_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        int is_fault;
        int paid;
        int code;
        int end_cyc;
        int motor;
        int pulses;
    } exp_t;

    exp_t exp_q[$];
    int   drop_q[$];   // sensor delay per hopper pulse, -1 = coin never drops
    int   width_q[$];  // expected width of each hopper pulse
    int   plan[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Coin sensor: after each hopper pulse starts, drop a coin after the planned delay.
    initial begin : sensor
        bit hp_prev;
        int cnt;
        int d;
        hp_prev = 1'b0;
        cnt = -1;
        coin_sense = 1'b0;
        forever begin
            @(negedge clk);
            coin_sense = 1'b0;
            if (rst) begin
                hp_prev = 1'b0;
                cnt = -1;
            end else begin
                if (hopper_pulse && !hp_prev) begin
                    d = (drop_q.size() != 0) ? drop_q.pop_front() : -1;
                    width_q.push_back((d >= 0 && d < P) ? d + 1 : P);
                    cnt = d;
                end
                if (cnt == 0) coin_sense = 1'b1;
                if (cnt >= 0) cnt--;
                hp_prev = hopper_pulse;
            end
        end
    end

    // Monitor: pops the scoreboard whenever a transaction completes or faults.
    initial begin : monitor
        int motor_cnt, pulse_cnt, hp_w;
        bit hp_prev, fault_prev, done_prev;
        exp_t e;
        motor_cnt = 0; pulse_cnt = 0; hp_w = 0;
        hp_prev = 0; fault_prev = 0; done_prev = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                motor_cnt = 0; pulse_cnt = 0; hp_w = 0;
                hp_prev = 0; fault_prev = 0; done_prev = 0;
                continue;
            end
            if (motor_on) motor_cnt++;
            if (hopper_pulse) begin
                if (!hp_prev) pulse_cnt++;
                hp_w++;
            end else if (hp_prev) begin
                if (width_q.size() == 0) check("pulse_width_unexpected", hp_w, 0);
                else check("pulse_width", hp_w, width_q.pop_front());
                hp_w = 0;
            end
            if (done_prev) check("req_ready_after_done", int'(req_ready), 1);
            if (done || (fault && !fault_prev)) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_completion", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("outcome_is_fault", int'(fault), e.is_fault);
                    check("coins_paid", int'(coins_paid), e.paid);
                    check("fault_code", int'(fault_code), e.code);
                    check("completion_cycle", cyc, e.end_cyc);
                    check("motor_cycles", motor_cnt, e.motor);
                    check("pulse_count", pulse_cnt, e.pulses);
                end
                motor_cnt = 0;
                pulse_cnt = 0;
            end
            if (fault) check("fault_quiet_outputs",
                             int'({req_ready, motor_on, hopper_pulse, busy}), 0);
            done_prev = done; fault_prev = fault; hp_prev = hopper_pulse;
        end
    end

    task automatic wait_ready();
        int n;
        n = 0;
        while (!req_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) check("wait_ready_timeout", 0, 1);
    endtask

    // Builds the expected result from the plan, then issues the request.
    task automatic issue(input bit bottle, input logic [1:0] chg, input int hold);
        exp_t e;
        int owed, lat, a, tries, d, h;
        bit got;
        e = '{default: 0};
        lat = 0;
        a = 0;
        if (chg == 2'b11) begin
            e.is_fault = 1;
            e.code = 2;
        end else begin
            owed = int'(chg);
            if (bottle) begin
                lat += M;
                e.motor = M;
            end
            while (owed > 0 && e.is_fault == 0) begin
                tries = 0;
                got = 0;
                while (!got && tries < 1 + R) begin
                    d = (a < plan.size()) ? plan[a] : -1;
                    a++; tries++; e.pulses++;
                    drop_q.push_back(d);
                    if (d >= 0 && d < P + T) begin
                        lat += d + 1;
                        got = 1;
                    end else begin
                        lat += P + T;
                    end
                end
                if (got) begin
                    owed--;
                    e.paid++;
                end else begin
                    e.is_fault = 1;
                    e.code = 1;
                end
            end
        end
        wait_ready();
        req_bottle = bottle;
        req_change = chg;
        req_valid  = 1'b1;
        e.end_cyc  = cyc + 1 + lat;
        exp_q.push_back(e);
        h = (hold > lat + 1) ? lat + 1 : hold;
        repeat (1 + h) @(negedge clk);
        req_valid  = 1'b0;
        req_change = 2'($urandom_range(0, 3));
        req_bottle = 1'($urandom_range(0, 1));
    endtask

    // Waits for the transaction to settle; clears a fault after probing that it ignores requests.
    task automatic settle();
        int n;
        n = 0;
        while (n < 400) begin
            if (fault) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                req_valid = 1'b1; req_bottle = 1'b1; req_change = 2'b01;
                @(negedge clk);
                req_valid = 1'b0;
                check("fault_ignores_req", int'(fault), 1);
                fault_clr = 1'b1;
                @(negedge clk);
                fault_clr = 1'b0;
                check("fault_clr_fault", int'(fault), 0);
                check("fault_clr_code", int'(fault_code), 0);
                check("fault_clr_ready", int'(req_ready), 1);
                return;
            end
            if (req_ready && exp_q.size() == 0) return;
            @(negedge clk);
            n++;
        end
        check("settle_timeout", 0, 1);
    endtask

    task automatic run(input bit bottle, input logic [1:0] chg, input int hold);
        issue(bottle, chg, hold);
        settle();
        plan.delete();
    endtask

    initial begin : watchdog
        #(50000 * 10);
        $display("FAIL watchdog expired at cycle %0d", cyc);
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin : stim
        int n_dc, n_mot, owed, ok;
        bit b;
        logic [1:0] c;
        rst = 1'b1; req_valid = 1'b0; req_bottle = 1'b0; req_change = 2'b00; fault_clr = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_req_ready", int'(req_ready), 1);
        check("rst_quiet", int'({motor_on, hopper_pulse, busy, done, fault}), 0);
        check("rst_paid_code", int'({coins_paid, fault_code}), 0);
        rst = 1'b0;
        @(negedge clk);

        run(1'b1, 2'b00, 0);                                    // bottle only
        plan = '{5, 5};  run(1'b1, 2'b10, 0);                   // bottle + 10 rs
        plan = '{-1, -1, -1}; run(1'b0, 2'b01, 0);              // drop timeout
        run(1'b1, 2'b11, 0);                                    // illegal request
        plan = '{1}; run(1'b0, 2'b01, 3);                       // early drop, req_valid held
        run(1'b0, 2'b00, 1);                                    // empty request

        // Reset in the middle of the motor interval.
        plan = '{6, 6};
        issue(1'b1, 2'b10, 0);
        repeat (3) @(negedge clk);
        check("motor_before_reset", int'(motor_on), 1);
        #2 rst = 1'b1;
        #1;
        check("reset_motor_async", int'(motor_on), 0);
        check("reset_ready_busy", int'({req_ready, busy}), 2);
        exp_q.delete(); drop_q.delete(); width_q.delete(); plan.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_dc = 0; n_mot = 0;
        repeat (30) begin
            @(negedge clk);
            n_dc  += int'(done);
            n_mot += int'(motor_on | hopper_pulse);
        end
        check("no_done_after_reset", n_dc, 0);
        check("no_actuation_after_reset", n_mot, 0);

        // Randomized payouts.
        for (int i = 0; i < 40; i++) begin
            b = 1'($urandom_range(0, 1));
            c = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            owed = (c == 2'b11) ? 0 : int'(c);
            for (int k = 0; k < owed; k++) begin
                ok = 0;
                for (int t = 0; t < 1 + R && ok == 0; t++) begin
                    if ($urandom_range(0, 2) == 0) begin
                        plan.push_back(-1);
                    end else begin
                        plan.push_back((k == owed - 1) ? int'($urandom_range(0, 15))
                                                       : int'($urandom_range(P, 15)));
                        ok = 1;
                    end
                end
                if (ok == 0) break;
            end
            run(b, c, int'($urandom_range(0, 3)));
        end

        repeat (5) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vend_payout_ctrl.md
Name: vend_payout_ctrl

Overview:
Payout actuator controller for the vending machine. It consumes the controller's dispense/change decision as a request with a valid/ready handshake. It runs the bottle motor, then pulses a 5 rs coin hopper once per coin owed, confirming each drop via the hopper's coin sensor. It reports completion or a sticky fault back to the controller side.

Parameters:
MOTOR_CYCLES, 8, cycles motor_on is held high per bottle (>=1)
PULSE_CYCLES, 4, width of each hopper_pulse in cycles (>=1)
TIMEOUT_CYCLES, 16, cycles to wait for a coin drop after a pulse ends (>=1)
MAX_RETRY, 2, extra hopper pulses allowed per coin before faulting

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  1  payout request strobe
req_bottle  in  1  1 = dispense one bottle
req_change  in  2  00 none, 01 5 rs, 10 10 rs, 11 illegal
req_ready  out  1  high only in IDLE
motor_on  out  1  bottle motor drive
hopper_pulse  out  1  coin hopper eject drive
coin_sense  in  1  hopper drop sensor, already synchronised; a rising edge = one coin dropped
busy  out  1  high in any state other than IDLE and FAULT
done  out  1  one-cycle pulse on successful completion
coins_paid  out  2  5 rs coins confirmed in current or last transaction
fault  out  1  sticky fault flag
fault_code  out  2  00 none, 01 drop timeout, 10 illegal request
fault_clr  in  1  clears fault, FAULT -> IDLE

Behaviour:
- Reset (async, active-high): state IDLE. All outputs 0 except req_ready=1. Internal counters and the coin_sense history flop are cleared. Reset mid-operation drops motor_on/hopper_pulse immediately; no payout resumes.
- Accept: a request is accepted on the rising edge where req_valid && req_ready. Fields are latched. coins_owed = 0/1/2 for change 00/01/10. coins_paid is cleared to 0. req_valid in any other state is ignored, with no queueing.
- States: IDLE, VEND, PULSE, WAIT_COIN, DONE, FAULT. Outputs are decoded from registered state.
- IDLE -> FAULT (code 10) if req_change==11; motor and hopper stay untouched.
- IDLE -> VEND if req_bottle, else PULSE if coins_owed>0, else DONE.
- VEND: motor_on=1 for exactly MOTOR_CYCLES cycles, then PULSE if coins_owed>0, else DONE.
- PULSE: hopper_pulse=1 for exactly PULSE_CYCLES cycles, then WAIT_COIN. The timeout timer and retry count restart each time PULSE is entered for a new coin.
- Coin edge detection: edge = coin_sense && !coin_sense_q. It is recognised in PULSE and WAIT_COIN only. An edge in PULSE ends the pulse early (hopper_pulse low the next cycle) and counts as the drop. Edges in other states are ignored.
- On a drop: coins_paid+1 and coins_owed-1. If coins_owed reaches 0, go to DONE; else go to PULSE for the next coin with retries reset.
- WAIT_COIN timeout: after TIMEOUT_CYCLES cycles with no edge:
  - if retries < MAX_RETRY: retries+1, back to PULSE;
  - else: FAULT with code 01.
- Pulse count: a coin is pulsed at most 1+MAX_RETRY times.
- DONE: done=1 for one cycle, then IDLE; req_ready is high again the cycle after done.
- FAULT: fault=1 and fault_code held. motor_on, hopper_pulse, busy, req_ready are all 0. coins_paid is held for diagnosis.
- fault_clr exits FAULT: sampled in FAULT only. The next cycle is IDLE with fault=0 and fault_code=00. fault_clr in other states has no effect.
- Latency at defaults:
  - bottle only, accepted at edge T: motor_on high cycles T+1..T+8, done at T+9;
  - empty request (00, no bottle): done at T+1.
- Width: coins_paid saturates at 2 by construction. Timers are sized $clog2(max(MOTOR_CYCLES,PULSE_CYCLES,TIMEOUT_CYCLES)+1).

Decomposition:
- Package vend_pkg holds the following, shared with the vending controller:
  - state enum;
  - change codes CHG_NONE=00, CHG_5=01, CHG_10=10, CHG_BAD=11;
  - fault codes FLT_NONE, FLT_TIMEOUT, FLT_BADREQ.
- One sub-module, vend_cycle_timer: a loadable down-counter with a zero flag. It is shared across the VEND, PULSE and WAIT_COIN intervals.

Test Plan:
- Bottle only (req_bottle=1, change=00) accepted at cycle 0 -> motor_on high cycles 1-8, hopper_pulse never high, done at cycle 9, coins_paid=0.
- Bottle + change=10, coin_sense rising 2 cycles after each pulse ends -> motor 8 cycles, then two hopper pulses of 4 cycles each, coins_paid=2, single done pulse, req_ready high the cycle after done.
- change=01 with coin_sense held low -> exactly 3 hopper pulses each followed by 16 idle cycles, then fault=1 and fault_code=01, req_ready=0. fault_clr for 1 cycle -> IDLE with fault=0 next cycle.
- req_change=11 -> next cycle fault=1 and fault_code=10, motor_on and hopper_pulse never asserted. A second req_valid while in FAULT is ignored.
- rst pulsed at cycle 4 of VEND -> motor_on low with no clock edge needed, req_ready=1 and busy=0 after release, no done pulse.
- Early drop: coin_sense rises in cycle 2 of PULSE (change=01, no bottle) -> hopper_pulse low the next cycle, done follows, coins_paid=1. A req_valid held during busy causes no second transaction.
